calc_operand_sequencer: RTL and testbench

CALC_OPERAND_SEQUENCER -- requirements
Module: calc_operand_sequencer

---
 rtl/calc_pkg.sv | 14 +
 rtl/calc_operand_sequencer.sv | 78 +++++++
 tb/tb_calc_operand_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator operand sequencer: the default
// datapath width and the sequencer FSM state encoding.
package calc_pkg;

    localparam int unsigned CALC_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GOT_A = 2'd1,
        EXEC  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/calc_operand_sequencer.sv
// Collects an A beat and a B/op beat, presents them to an external
// combinational Calculator, captures its result and holds it until consumed.
module calc_operand_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = CALC_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_op,
    input  logic             clear,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             Op,
    input  logic [WIDTH-1:0] Out,
    input  logic             cy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_cy,
    output logic [7:0]       op_count
);

    state_t state;

    assign in_ready = (state == IDLE) || (state == GOT_A);

    // clear aborts from any state but leaves operands and the count intact
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            A         <= '0;
            B         <= '0;
            Op        <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_cy    <= 1'b0;
            op_count  <= '0;
        end else if (clear) begin
            state     <= IDLE;
            res_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        A     <= in_data;
                        state <= GOT_A;
                    end
                end
                GOT_A: begin
                    if (in_valid) begin
                        B     <= in_data;
                        Op    <= in_op;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    res_data  <= Out;
                    res_cy    <= cy;
                    res_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + 8'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Bench for calc_operand_sequencer with a Calculator reference model and a
// result scoreboard.
module tb_calc_operand_sequencer;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_op;
    logic         clear;
    logic [W-1:0] A, B;
    logic         Op;
    logic [W-1:0] Out;
    logic         cy;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         res_cy;
    logic [7:0]   op_count;

    int   checks = 0;
    int   fails  = 0;
    logic [7:0]   exp_count;
    logic [W-1:0] last_b;
    logic         last_op;
    logic [W:0]   sb[$];
    logic [W:0]   exp;
    logic [W:0]   calc;

    always #5 clk = ~clk;

    // Calculator: sum for Op=0, difference for Op=1, top bit is carry/borrow
    always_comb begin
        calc = Op ? ({1'b0, A} - {1'b0, B}) : ({1'b0, A} + {1'b0, B});
        Out  = calc[W-1:0];
        cy   = calc[W];
    end

    calc_operand_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_op(in_op), .clear(clear), .A(A), .B(B), .Op(Op),
        .Out(Out), .cy(cy), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_cy(res_cy), .op_count(op_count)
    );

    // Starts and ends just after a falling edge; leaves the DUT in EXEC.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        in_valid = 1'b1; in_data = a;
        @(negedge clk);
        in_data = b; in_op = op;
        @(negedge clk);
        in_valid = 1'b0;
        last_b = b; last_op = op;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_op = 1'b0;
        clear = 1'b0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (A !== '0) begin fails++; $display("FAIL reset_A: got %0h expected 0", A); end
        checks++; if (B !== '0) begin fails++; $display("FAIL reset_B: got %0h expected 0", B); end
        checks++; if (Op !== 1'b0) begin fails++; $display("FAIL reset_Op: got %b expected 0", Op); end
        checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
        checks++; if (res_data !== '0) begin fails++; $display("FAIL reset_res_data: got %0h expected 0", res_data); end
        checks++; if (res_cy !== 1'b0) begin fails++; $display("FAIL reset_res_cy: got %b expected 0", res_cy); end
        checks++; if (op_count !== 8'd0) begin fails++; $display("FAIL reset_op_count: got %0d expected 0", op_count); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        rst_n = 1'b1;
        exp_count = 8'd0;
    endtask

    task automatic test_add_latency();
        res_ready = 1'b1;
        sb.push_back({1'b0, 4'd10});
        send(4'd8, 4'd2, 1'b0);
        checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL lat_exec_valid: got %b expected 0", res_valid); end
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL lat_exec_ready: got %b expected 0", in_ready); end
        @(negedge clk);
        checks++; if (res_valid !== 1'b1) begin fails++; $display("FAIL lat_valid: got %b expected 1", res_valid); end
        exp = sb.pop_front();
        checks++; if ({res_cy, res_data} !== exp) begin fails++; $display("FAIL add_result: got %0h expected %0h", {res_cy, res_data}, exp); end
        checks++; if ({A, B, Op} !== {4'd8, 4'd2, 1'b0}) begin fails++; $display("FAIL add_operands: got %0h/%0h/%b expected 8/2/0", A, B, Op); end
        @(negedge clk);
        exp_count++;
        checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL add_release: got %b expected 0", res_valid); end
        checks++; if (op_count !== exp_count) begin fails++; $display("FAIL add_count: got %0d expected %0d", op_count, exp_count); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL add_idle_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_backpressure();
        res_ready = 1'b0;
        sb.push_back({1'b0, 4'd1});
        send(4'd4, 4'd3, 1'b1);
        @(negedge clk);
        exp = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 4'd9; in_op = 1'b0;
            checks++; if (res_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, res_valid); end
            checks++; if ({res_cy, res_data} !== exp) begin fails++; $display("FAIL bp_result[%0d]: got %0h expected %0h", i, {res_cy, res_data}, exp); end
            checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
            checks++; if ({A, B, Op} !== {4'd4, 4'd3, 1'b1}) begin fails++; $display("FAIL bp_operands[%0d]: got %0h/%0h/%b expected 4/3/1", i, A, B, Op); end
            @(negedge clk);
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        exp_count++;
        checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL bp_release: got %b expected 0", res_valid); end
        checks++; if (op_count !== exp_count) begin fails++; $display("FAIL bp_count: got %0d expected %0d", op_count, exp_count); end
    endtask

    task automatic test_carry_borrow();
        bit ok;
        res_ready = 1'b1;
        sb.push_back({1'b1, 4'd0});
        send(4'd15, 4'd1, 1'b0);
        wait_valid(ok);
        exp = sb.pop_front();
        checks++; if (!ok) begin fails++; $display("FAIL carry_timeout: got no res_valid expected res_valid"); end
        else if ({res_cy, res_data} !== exp) begin fails++; $display("FAIL carry_result: got %0h expected %0h", {res_cy, res_data}, exp); end
        @(negedge clk);
        exp_count++;
        sb.push_back({1'b1, 4'd13});
        send(4'd2, 4'd5, 1'b1);
        wait_valid(ok);
        exp = sb.pop_front();
        checks++; if (!ok) begin fails++; $display("FAIL borrow_timeout: got no res_valid expected res_valid"); end
        else if ({res_cy, res_data} !== exp) begin fails++; $display("FAIL borrow_result: got %0h expected %0h", {res_cy, res_data}, exp); end
        @(negedge clk);
        exp_count++;
        checks++; if (op_count !== exp_count) begin fails++; $display("FAIL carry_count: got %0d expected %0d", op_count, exp_count); end
    endtask

    task automatic test_clear();
        bit ok;
        res_ready = 1'b1;
        in_valid = 1'b1; in_data = 4'd6;
        @(negedge clk);
        clear = 1'b1; in_data = 4'd7; in_op = ~last_op;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL clr_gota_valid: got %b expected 0", res_valid); end
        checks++; if (op_count !== exp_count) begin fails++; $display("FAIL clr_gota_count: got %0d expected %0d", op_count, exp_count); end
        checks++; if ({A, B, Op} !== {4'd6, last_b, last_op}) begin fails++; $display("FAIL clr_gota_operands: got %0h/%0h/%b expected %0h/%0h/%b", A, B, Op, 4'd6, last_b, last_op); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL clr_gota_ready: got %b expected 1", in_ready); end
        sb.push_back({1'b0, 4'd11});
        send(4'd5, 4'd6, 1'b0);
        wait_valid(ok);
        exp = sb.pop_front();
        checks++; if (!ok) begin fails++; $display("FAIL clr_after_timeout: got no res_valid expected res_valid"); end
        else if ({res_cy, res_data} !== exp) begin fails++; $display("FAIL clr_after_result: got %0h expected %0h", {res_cy, res_data}, exp); end
        @(negedge clk);
        exp_count++;
        res_ready = 1'b0;
        send(4'd3, 4'd3, 1'b1);
        @(negedge clk);
        checks++; if (res_valid !== 1'b1) begin fails++; $display("FAIL clr_done_pre: got %b expected 1", res_valid); end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL clr_done_valid: got %b expected 0", res_valid); end
        checks++; if (op_count !== exp_count) begin fails++; $display("FAIL clr_done_count: got %0d expected %0d", op_count, exp_count); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL clr_done_ready: got %b expected 1", in_ready); end
        res_ready = 1'b1;
        sb.push_back({1'b0, 4'd5});
        send(4'd9, 4'd4, 1'b1);
        wait_valid(ok);
        exp = sb.pop_front();
        checks++; if (!ok) begin fails++; $display("FAIL clr_resume_timeout: got no res_valid expected res_valid"); end
        else if ({res_cy, res_data} !== exp) begin fails++; $display("FAIL clr_resume_result: got %0h expected %0h", {res_cy, res_data}, exp); end
        @(negedge clk);
        exp_count++;
        checks++; if (op_count !== exp_count) begin fails++; $display("FAIL clr_resume_count: got %0d expected %0d", op_count, exp_count); end
    endtask

    task automatic test_reset_mid_exec();
        res_ready = 1'b1;
        send(4'd7, 4'd7, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL arst_valid: got %b expected 0", res_valid); end
        checks++; if ({A, B, Op} !== '0) begin fails++; $display("FAIL arst_operands: got %0h/%0h/%b expected 0/0/0", A, B, Op); end
        checks++; if ({res_cy, res_data} !== '0) begin fails++; $display("FAIL arst_result: got %0h expected 0", {res_cy, res_data}); end
        checks++; if (op_count !== 8'd0) begin fails++; $display("FAIL arst_count: got %0d expected 0", op_count); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 8'd0;
        @(negedge clk);
        checks++; if (res_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL arst_discard: got valid=%b ready=%b expected valid=0 ready=1", res_valid, in_ready); end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [W-1:0] a, b;
        logic op;
        res_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            a  = W'($urandom_range(0, 15));
            b  = W'($urandom_range(0, 15));
            op = 1'($urandom_range(0, 1));
            sb.push_back(op ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b}));
            send(a, b, op);
            wait_valid(ok);
            exp = sb.pop_front();
            checks++; if (!ok) begin fails++; $display("FAIL wrap_timeout[%0d]: got no res_valid expected res_valid", i); end
            else if ({res_cy, res_data} !== exp) begin fails++; $display("FAIL wrap_result[%0d]: got %0h expected %0h", i, {res_cy, res_data}, exp); end
            @(negedge clk);
            exp_count++;
            checks++; if (op_count !== exp_count) begin fails++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", i, op_count, exp_count); end
        end
        checks++; if (op_count !== 8'd0) begin fails++; $display("FAIL wrap_final: got %0d expected 0", op_count); end
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_backpressure();
        test_carry_borrow();
        test_clear();
        test_reset_mid_exec();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
